// File: rtl/lep_pkg.sv
// Shared definitions for the thermal AGC normaliser.
//   state_e     : handshake FSM state encoding
//   MODE_AUTO   : window taken from the previous frame's latched min/max
//   MODE_MANUAL : window taken from cfg_lo/cfg_hi
package lep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/lep_div_serial.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load num/den and begin (ignored while busy)
//   num        : IN_W+OUT_W bit numerator; its upper IN_W bits must be < den
//   den        : IN_W+1 bit non-zero denominator
//   busy       : iterations in progress
//   done       : one-cycle pulse, quo valid from this cycle until next start
//   quo        : OUT_W bit quotient
module lep_div_serial
  import lep_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W+OUT_W-1:0] num,
  input  logic [IN_W:0]         den,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      quo
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [IN_W:0]      rem_q, rem_d;
  logic [IN_W:0]      den_q, den_d;
  logic [OUT_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Because the upper numerator part is already below den, only the OUT_W
  // low numerator bits need iterating. sh_q shifts those bits out at the top
  // while quotient bits shift in at the bottom.
  logic [IN_W+1:0]    rem_sh;
  logic [IN_W+1:0]    rem_sub;
  logic               ge;

  always_comb begin
    rem_sh  = {rem_q, sh_q[OUT_W-1]};
    rem_sub = rem_sh - {1'b0, den_q};
    ge      = (rem_sh >= {1'b0, den_q});

    rem_d  = rem_q;
    den_d  = den_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (busy_q) begin
      rem_d = ge ? rem_sub[IN_W:0] : rem_sh[IN_W:0];
      sh_d  = {sh_q[OUT_W-2:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = {1'b0, num[IN_W+OUT_W-1:OUT_W]};
      den_d  = den;
      sh_d   = num[OUT_W-1:0];
      cnt_d  = CNT_W'(OUT_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = sh_q;

endmodule

// File: rtl/lep_agc_norm.sv
// Thermal pixel automatic-gain normaliser.
// Maps a raw IN_W-bit pixel into OUT_W bits over a window (lo, hi) taken
// either from the previous frame's min/max or from a manual configuration:
//   out = floor(((p-lo) << OUT_W) / (hi-lo+1)), clamped to 0 / all-ones.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   frame_start           : one-cycle new-frame pulse (latches running range)
//   cfg_mode              : MODE_AUTO / MODE_MANUAL
//   cfg_lo, cfg_hi        : manual window
//   in_valid/in_ready/in_data    : input pixel handshake
//   out_valid/out_ready/out_data : output pixel handshake
//   stats_min, stats_max  : latched range of the previous frame
module lep_agc_norm
  import lep_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             cfg_mode,
  input  logic [IN_W-1:0]  cfg_lo,
  input  logic [IN_W-1:0]  cfg_hi,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic [IN_W-1:0]  stats_min,
  output logic [IN_W-1:0]  stats_max
);

  state_e state_q, state_d;

  logic [IN_W-1:0]  run_min_q, run_min_d;
  logic [IN_W-1:0]  run_max_q, run_max_d;
  logic             seen_q, seen_d;
  logic [IN_W-1:0]  stats_min_q, stats_min_d;
  logic [IN_W-1:0]  stats_max_q, stats_max_d;
  logic             sat_q, sat_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             accept;
  logic [IN_W-1:0]  eff_min, eff_max;
  logic [IN_W-1:0]  lo_raw, hi_raw, lo, hi;
  logic             below, above;
  logic [IN_W:0]    den;
  logic [IN_W+OUT_W-1:0] num;

  logic             div_start, div_busy, div_done;
  logic [OUT_W-1:0] div_quo;

  assign accept = in_valid && (state_q == ST_IDLE);

  // Range tracker. A coincident frame_start latches first, so the window
  // seen by an accepted pixel is the freshly latched range.
  always_comb begin
    eff_min = (frame_start && seen_q) ? run_min_q : stats_min_q;
    eff_max = (frame_start && seen_q) ? run_max_q : stats_max_q;

    stats_min_d = eff_min;
    stats_max_d = eff_max;
    run_min_d   = run_min_q;
    run_max_d   = run_max_q;
    seen_d      = seen_q;

    if (frame_start) begin
      // New frame: the coincident pixel (if any) seeds the running range.
      run_min_d = accept ? in_data : '1;
      run_max_d = accept ? in_data : '0;
      seen_d    = accept;
    end else if (accept) begin
      if (in_data < run_min_q) run_min_d = in_data;
      if (in_data > run_max_q) run_max_d = in_data;
      seen_d = 1'b1;
    end
  end

  // Window selection and divider operands, evaluated at acceptance.
  always_comb begin
    lo_raw = (cfg_mode == MODE_MANUAL) ? cfg_lo : eff_min;
    hi_raw = (cfg_mode == MODE_MANUAL) ? cfg_hi : eff_max;
    if (hi_raw < lo_raw) begin
      lo = cfg_lo;
      hi = cfg_lo;
    end else begin
      lo = lo_raw;
      hi = hi_raw;
    end
    below = (in_data < lo);
    above = (in_data > hi);
    den   = {1'b0, hi} - {1'b0, lo} + (IN_W+1)'(1);
    // Clamped pixels still run the divider so latency stays fixed.
    num   = (below || above) ? '0 : {in_data - lo, {OUT_W{1'b0}}};
  end

  assign div_start = accept && !div_busy;

  lep_div_serial #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Handshake FSM.
  always_comb begin
    state_d    = state_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DIV;
          sat_d   = above;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d    = ST_HOLD;
          out_data_d = sat_q ? '1 : div_quo;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      run_min_q   <= '1;
      run_max_q   <= '0;
      seen_q      <= 1'b0;
      stats_min_q <= '0;
      stats_max_q <= '1;
    end else begin
      state_q     <= state_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      run_min_q   <= run_min_d;
      run_max_q   <= run_max_d;
      seen_q      <= seen_d;
      stats_min_q <= stats_min_d;
      stats_max_q <= stats_max_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign stats_min = stats_min_q;
  assign stats_max = stats_max_q;

endmodule

// File: doc/lep_agc_norm.md
LEP_AGC_NORM -- requirements
Module: lep_agc_norm

Interface
REQ-001 The module SHALL have these parameters:
- IN_W, default 16: raw thermal pixel width.
- OUT_W, default 8: normalised output width; legal range 4..12.
REQ-002 The module SHALL have these ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse marking the start of a new frame.
- cfg_mode  in  1  0 = auto range from the previous frame's min/max; 1 = manual window.
- cfg_lo  in  IN_W  lower bound of the manual window.
- cfg_hi  in  IN_W  upper bound of the manual window.
- in_valid  in  1  raw pixel present.
- in_data  in  IN_W  raw pixel.
- in_ready  out  1  block can accept a pixel.
- out_valid  out  1  normalised pixel present.
- out_data  out  OUT_W  normalised pixel.
- out_ready  in  1  downstream accepts out_data.
- stats_min  out  IN_W  latched minimum of the previous frame.
- stats_max  out  IN_W  latched maximum of the previous frame.

Function
REQ-003 A pixel SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-004 At acceptance the block SHALL sample in_data and cfg_mode, and the window (lo, hi) SHALL be taken as follows:
- mode 0: the latched (stats_min, stats_max).
- mode 1: (cfg_lo, cfg_hi).
REQ-005 Output SHALL be out_data = floor(((p-lo) << OUT_W) / (hi-lo+1)), with these boundary cases:
- p < lo gives 0.
- p > hi gives 2^OUT_W-1.
- If hi < lo, the window SHALL be treated as lo=hi=cfg_lo.
REQ-006 The numerator SHALL be IN_W+OUT_W bits and the denominator IN_W+1 bits; no intermediate value may overflow.
REQ-007 The division SHALL be serial restoring division producing one quotient bit per cycle, MSB first, OUT_W iterations.
REQ-008 The FSM SHALL have states IDLE, DIV, HOLD, with these transitions:
- IDLE to DIV on acceptance.
- DIV to HOLD after OUT_W iteration cycles.
- HOLD to IDLE on out_ready.
REQ-009 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-010 Latency SHALL be fixed: out_valid rises OUT_W+1 cycles after the acceptance edge.
REQ-011 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 Running min/max SHALL update on every accepted pixel.
REQ-013 On frame_start, the running min/max SHALL be transferred to stats_min/stats_max, provided at least one pixel was accepted since the previous frame_start; the running registers then reset to min=all-ones, max=0.
REQ-014 If frame_start and an acceptance coincide:
- the latch SHALL occur first;
- the pixel SHALL use the newly latched range;
- the pixel SHALL seed the new frame's running min/max.
REQ-015 frame_start while in DIV or HOLD SHALL NOT disturb the in-flight pixel, which completes with its sampled window.
REQ-016 Changes to cfg_* while in DIV or HOLD SHALL NOT affect the in-flight result.

Reset
REQ-017 Asserting rst_n=0 SHALL asynchronously force:
- state to IDLE;
- out_valid=0 and out_data=0;
- stats_min=0 and stats_max=2^IN_W-1;
- running min = all-ones and running max = 0;
- the pixel-seen flag to 0.
REQ-018 Reset during DIV or HOLD SHALL discard the in-flight pixel without emitting it.
REQ-019 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Structure
REQ-020 Package lep_pkg SHALL hold the FSM state encoding and the cfg_mode constants MODE_AUTO and MODE_MANUAL.
REQ-021 The serial divider SHALL be a sub-module, lep_div_serial, parametrised by IN_W and OUT_W, with start, busy and done signals.
REQ-022 The range tracker and the handshake FSM SHALL remain in lep_agc_norm.

Verification (IN_W=16, OUT_W=8)
REQ-023 Reset release, mode 0, no frame seen, pixel 32768 -> out_data 128 at cycle 9 after acceptance.
REQ-024 Frame of pixels spanning 1000..2000, then frame_start:
- stats 1000/2000;
- pixels 1500, 2000, 900, 2500 -> 127, 255, 0, 255.
REQ-025 Mode 1, cfg_lo=0, cfg_hi=255:
- pixel 100 -> 100;
- cfg_lo=cfg_hi=500, pixel 500 -> 0.
REQ-026 out_ready held 0 for 20 cycles -> out_data stable, in_ready=0 throughout; one release cycle -> in_ready=1 the next cycle.
REQ-027 Both coincidence cases:
- frame_start coincident with acceptance -> new range applied to that pixel;
- frame_start during DIV -> in-flight result uses the old range.
REQ-028 rst_n pulsed low mid-DIV -> no out_valid is emitted, and stats reset to 0/65535.
